xadac_if_arb: RTL and testbench

//  Shares one xadac accelerator port among NumSrc requesters (cores/issue ports).

---
 rtl/xadac_if_arb_pkg.sv | 30 +++
 rtl/xadac_if_arb_if.sv | 34 +++
 rtl/xadac_if_arb_rr.sv | 52 +++++
 rtl/xadac_if_arb.sv | 122 ++++++++++++
 tb/tb_xadac_if_arb.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xadac_if_arb_pkg.sv
// Payload types and sizing helpers for the xadac port arbiter slice.
// Payloads are opaque to the arbiter; it only steers them.
package xadac_if_arb_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  tag;
    } dec_req_t;

    typedef struct packed {
        logic        accept;
        logic [7:0]  tag;
    } dec_rsp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [7:0]  tag;
    } exe_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  tag;
    } exe_rsp_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/xadac_if_arb_if.sv
// xadac accelerator port: decode and execute channels, each a
// valid/ready request plus a valid/ready response.
interface xadac_if_arb_if;
    import xadac_if_arb_pkg::*;

    dec_req_t dec_req;
    logic     dec_req_valid;
    logic     dec_req_ready;
    dec_rsp_t dec_rsp;
    logic     dec_rsp_valid;
    logic     dec_rsp_ready;

    exe_req_t exe_req;
    logic     exe_req_valid;
    logic     exe_req_ready;
    exe_rsp_t exe_rsp;
    logic     exe_rsp_valid;
    logic     exe_rsp_ready;

    modport mst (
        output dec_req, dec_req_valid, dec_rsp_ready,
        input  dec_req_ready, dec_rsp, dec_rsp_valid,
        output exe_req, exe_req_valid, exe_rsp_ready,
        input  exe_req_ready, exe_rsp, exe_rsp_valid
    );

    modport slv (
        input  dec_req, dec_req_valid, dec_rsp_ready,
        output dec_req_ready, dec_rsp, dec_rsp_valid,
        input  exe_req, exe_req_valid, exe_rsp_ready,
        output exe_req_ready, exe_rsp, exe_rsp_valid
    );

endinterface

// File: rtl/xadac_if_arb_rr.sv
// Round-robin picker with grant lock while the winner is stalled.
// Search starts one past the last accepted source.
module xadac_if_arb_rr #(
    parameter  int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         hold,
    input  logic         accept,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    logic [W-1:0] ptr_q, lidx_q, pick;
    logic         lock_q, found;
    logic [W:0]   cand;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (W+1)'(k);
            if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
            if (!found && req[cand[W-1:0]]) begin
                found = 1'b1;
                pick  = cand[W-1:0];
            end
        end
    end

    always_comb begin
        idx = lock_q ? lidx_q : pick;
        gnt = '0;
        if (lock_q || found) gnt[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            lidx_q <= '0;
            lock_q <= 1'b0;
        end else begin
            lock_q <= hold;
            lidx_q <= idx;
            if (accept)
                ptr_q <= (idx == W'(N-1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/xadac_if_arb.sv
// Shares one xadac port among NumSrc requesters; dec and exe are
// arbitrated independently and responses steered by source FIFOs.
module xadac_if_arb
    import xadac_if_arb_pkg::*;
#(
    parameter int NumSrc    = 2,
    parameter int DecMaxOut = 2,
    parameter int ExeMaxOut = 4
) (
    input logic         clk,
    input logic         rst,
    xadac_if_arb_if.slv slv [NumSrc],
    xadac_if_arb_if.mst mst
);
    localparam int SW  = $clog2(NumSrc);
    localparam int DPW = ptr_w(DecMaxOut);
    localparam int EPW = ptr_w(ExeMaxOut);
    localparam int DCW = $clog2(DecMaxOut + 1);
    localparam int ECW = $clog2(ExeMaxOut + 1);

    typedef logic [SW-1:0] src_idx_t;

    dec_req_t          d_req [NumSrc];
    exe_req_t          e_req [NumSrc];
    logic [NumSrc-1:0] d_qv, d_sr, d_gnt;
    logic [NumSrc-1:0] e_qv, e_sr, e_gnt;
    src_idx_t          d_idx, d_head, e_idx, e_head;
    src_idx_t          d_fifo [DecMaxOut];
    src_idx_t          e_fifo [ExeMaxOut];
    logic [DPW-1:0]    d_wr, d_rd;
    logic [EPW-1:0]    e_wr, e_rd;
    logic [DCW-1:0]    d_cnt;
    logic [ECW-1:0]    e_cnt;
    logic              d_full, d_empty, d_push, d_pop, d_hold;
    logic              e_full, e_empty, e_push, e_pop, e_hold;

    for (genvar i = 0; i < NumSrc; i++) begin : g_src
        assign d_req[i] = slv[i].dec_req;
        assign d_qv[i]  = slv[i].dec_req_valid;
        assign d_sr[i]  = slv[i].dec_rsp_ready;
        assign e_req[i] = slv[i].exe_req;
        assign e_qv[i]  = slv[i].exe_req_valid;
        assign e_sr[i]  = slv[i].exe_rsp_ready;

        assign slv[i].dec_req_ready = !rst && d_gnt[i] && mst.dec_req_ready && !d_full;
        assign slv[i].dec_rsp       = mst.dec_rsp;
        assign slv[i].dec_rsp_valid = !rst && !d_empty && mst.dec_rsp_valid
                                      && (d_head == SW'(i));
        assign slv[i].exe_req_ready = !rst && e_gnt[i] && mst.exe_req_ready && !e_full;
        assign slv[i].exe_rsp       = mst.exe_rsp;
        assign slv[i].exe_rsp_valid = !rst && !e_empty && mst.exe_rsp_valid
                                      && (e_head == SW'(i));
    end

    xadac_if_arb_rr #(.N(NumSrc)) u_dec_rr (
        .clk, .rst, .req(d_qv), .hold(d_hold),
        .accept(d_push), .gnt(d_gnt), .idx(d_idx)
    );

    xadac_if_arb_rr #(.N(NumSrc)) u_exe_rr (
        .clk, .rst, .req(e_qv), .hold(e_hold),
        .accept(e_push), .gnt(e_gnt), .idx(e_idx)
    );

    // Full/empty come from registered counts, so a pop never frees a slot
    // for a push in the same cycle.
    assign d_full  = (d_cnt == DCW'(DecMaxOut));
    assign d_empty = (d_cnt == '0);
    assign d_head  = d_fifo[d_rd];
    assign e_full  = (e_cnt == ECW'(ExeMaxOut));
    assign e_empty = (e_cnt == '0);
    assign e_head  = e_fifo[e_rd];

    assign mst.dec_req       = d_req[d_idx];
    assign mst.dec_req_valid = !rst && !d_full && d_qv[d_idx] && d_gnt[d_idx];
    assign mst.dec_rsp_ready = !rst && !d_empty && d_sr[d_head];
    assign mst.exe_req       = e_req[e_idx];
    assign mst.exe_req_valid = !rst && !e_full && e_qv[e_idx] && e_gnt[e_idx];
    assign mst.exe_rsp_ready = !rst && !e_empty && e_sr[e_head];

    assign d_push = mst.dec_req_valid && mst.dec_req_ready;
    assign d_hold = mst.dec_req_valid && !mst.dec_req_ready;
    assign d_pop  = mst.dec_rsp_valid && mst.dec_rsp_ready;
    assign e_push = mst.exe_req_valid && mst.exe_req_ready;
    assign e_hold = mst.exe_req_valid && !mst.exe_req_ready;
    assign e_pop  = mst.exe_rsp_valid && mst.exe_rsp_ready;

    always_ff @(posedge clk) begin
        if (d_push) d_fifo[d_wr] <= d_idx;
        if (e_push) e_fifo[e_wr] <= e_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_wr  <= '0;
            d_rd  <= '0;
            d_cnt <= '0;
            e_wr  <= '0;
            e_rd  <= '0;
            e_cnt <= '0;
        end else begin
            if (d_push) d_wr <= (d_wr == DPW'(DecMaxOut-1)) ? '0 : d_wr + 1'b1;
            if (d_pop)  d_rd <= (d_rd == DPW'(DecMaxOut-1)) ? '0 : d_rd + 1'b1;
            if (d_push != d_pop)
                d_cnt <= d_push ? d_cnt + 1'b1 : d_cnt - 1'b1;
            if (e_push) e_wr <= (e_wr == EPW'(ExeMaxOut-1)) ? '0 : e_wr + 1'b1;
            if (e_pop)  e_rd <= (e_rd == EPW'(ExeMaxOut-1)) ? '0 : e_rd + 1'b1;
            if (e_push != e_pop)
                e_cnt <= e_push ? e_cnt + 1'b1 : e_cnt - 1'b1;
        end
    end

    a_dec_rsp_empty: assert property (@(posedge clk) disable iff (rst)
        !(mst.dec_rsp_valid && d_empty));
    a_exe_rsp_empty: assert property (@(posedge clk) disable iff (rst)
        !(mst.exe_rsp_valid && e_empty));
    a_dec_stable: assert property (@(posedge clk) disable iff (rst)
        mst.dec_req_valid && !mst.dec_req_ready |=> $stable(mst.dec_req));
    a_exe_stable: assert property (@(posedge clk) disable iff (rst)
        mst.exe_req_valid && !mst.exe_req_ready |=> $stable(mst.exe_req));

endmodule

// File: tb/tb_xadac_if_arb.sv
// Randomised bench for xadac_if_arb: queue-based reference model,
// per-cycle expectation scoreboard and end-to-end response tags.
module tb_xadac_if_arb;

    logic clk;
    logic rst;

    xadac_if_arb_if s_if [2] ();
    xadac_if_arb_if m_if ();

    xadac_if_arb #(.NumSrc(2), .DecMaxOut(2), .ExeMaxOut(4)) dut (
        .clk(clk), .rst(rst), .slv(s_if), .mst(m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // index [c][i]: c=0 dec, c=1 exe; i = source
    logic        rqv [2][2];
    logic [7:0]  rqt [2][2];
    logic [31:0] rqi [2][2];
    logic        rsr [2][2];
    logic        rqr [2][2];
    logic        rsv [2][2];
    logic [7:0]  rst_tag [2][2];
    logic        mqr [2];
    logic        msv [2];
    logic [7:0]  mst_tag [2];
    logic        mqv [2];
    logic [7:0]  mqt [2];
    logic [31:0] mqi [2];
    logic        msr [2];

    for (genvar i = 0; i < 2; i++) begin : g_s
        assign s_if[i].dec_req       = '{instr: rqi[0][i], tag: rqt[0][i]};
        assign s_if[i].dec_req_valid = rqv[0][i];
        assign s_if[i].dec_rsp_ready = rsr[0][i];
        assign rqr[0][i]             = s_if[i].dec_req_ready;
        assign rsv[0][i]             = s_if[i].dec_rsp_valid;
        assign rst_tag[0][i]         = s_if[i].dec_rsp.tag;
        assign s_if[i].exe_req       = '{instr: rqi[1][i], rs1: ~rqi[1][i], tag: rqt[1][i]};
        assign s_if[i].exe_req_valid = rqv[1][i];
        assign s_if[i].exe_rsp_ready = rsr[1][i];
        assign rqr[1][i]             = s_if[i].exe_req_ready;
        assign rsv[1][i]             = s_if[i].exe_rsp_valid;
        assign rst_tag[1][i]         = s_if[i].exe_rsp.tag;
    end

    assign m_if.dec_req_ready = mqr[0];
    assign m_if.dec_rsp       = '{accept: 1'b1, tag: mst_tag[0]};
    assign m_if.dec_rsp_valid = msv[0];
    assign mqv[0]             = m_if.dec_req_valid;
    assign mqt[0]             = m_if.dec_req.tag;
    assign mqi[0]             = m_if.dec_req.instr;
    assign msr[0]             = m_if.dec_rsp_ready;
    assign m_if.exe_req_ready = mqr[1];
    assign m_if.exe_rsp       = '{data: 32'(mst_tag[1]), tag: mst_tag[1]};
    assign m_if.exe_rsp_valid = msv[1];
    assign mqv[1]             = m_if.exe_req_valid;
    assign mqt[1]             = m_if.exe_req.tag;
    assign mqi[1]             = m_if.exe_req.instr;
    assign msr[1]             = m_if.exe_rsp_ready;

    typedef struct packed {
        logic [1:0]        mv;
        logic [1:0][7:0]   mt;
        logic [1:0][31:0]  mi;
        logic [1:0][1:0]   rdy;
        logic [1:0][1:0]   rv;
        logic [1:0]        mrr;
    } exp_t;

    exp_t eq [$];
    int   checks = 0;
    int   errors = 0;

    // reference model: depth-limited order queues + round-robin start
    int fq  [2][$];
    int exq [4][$];
    int ptr [2];
    int lck [2];
    int dep [2] = '{2, 4};

    // requester and accelerator behaviour
    bit          pend [2][2];
    logic [7:0]  ptag [2][2];
    logic [31:0] pins [2][2];
    int          accq [2][$];
    bit          arv  [2];
    logic [7:0]  artag [2];
    logic [7:0]  seq = 8'd0;

    int unsigned p_req, p_mrdy, p_rsp, p_rrdy;
    bit          msk [2];

    task automatic chk(input string nm, input int c, input int s,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d src%0d got %0h want %0h", nm, c, s, act, exp);
        end
    endtask

    function automatic bit roll(input int unsigned p);
        return $urandom_range(99) < p;
    endfunction

    task automatic model(input bit r);
        exp_t e;
        int   g, h, s;
        bit   full, mv;
        e = '0;
        for (int c = 0; c < 2; c++) begin
            full = fq[c].size() >= dep[c];
            g = -1;
            if (lck[c] >= 0) g = lck[c];
            else
                for (int k = 0; k < 2; k++) begin
                    s = (ptr[c] + k) % 2;
                    if (g < 0 && rqv[c][s]) g = s;
                end
            mv = !r && !full && g >= 0 && rqv[c][g];
            e.mv[c] = mv;
            if (mv) begin
                e.mt[c] = rqt[c][g];
                e.mi[c] = rqi[c][g];
            end
            for (int i = 0; i < 2; i++)
                e.rdy[c][i] = !r && i == g && mqr[c] && !full;
            h = (fq[c].size() > 0) ? fq[c][0] : -1;
            for (int i = 0; i < 2; i++)
                e.rv[c][i] = !r && h == i && msv[c];
            e.mrr[c] = !r && h >= 0 && rsr[c][h];
            if (r) begin
                fq[c].delete();
                exq[c*2].delete();
                exq[c*2+1].delete();
                ptr[c] = 0;
                lck[c] = -1;
            end else begin
                if (mv && mqr[c]) begin
                    fq[c].push_back(g);
                    exq[c*2+g].push_back(int'(rqt[c][g]));
                    ptr[c] = (g + 1) % 2;
                    lck[c] = -1;
                end else if (mv) lck[c] = g;
                else lck[c] = -1;
                if (e.mrr[c] && msv[c]) void'(fq[c].pop_front());
            end
        end
        eq.push_back(e);
    endtask

    task automatic cycle(input bit r);
        @(negedge clk);
        rst = r;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[c][i] && msk[i] && roll(p_req)) begin
                    pend[c][i] = 1'b1;
                    ptag[c][i] = seq;
                    pins[c][i] = $urandom;
                    seq        = seq + 8'd1;
                end
                rqv[c][i] = pend[c][i];
                rqt[c][i] = ptag[c][i];
                rqi[c][i] = pins[c][i];
                rsr[c][i] = roll(p_rrdy);
            end
            mqr[c] = roll(p_mrdy);
            if (!arv[c] && accq[c].size() > 0 && roll(p_rsp)) begin
                arv[c]   = 1'b1;
                artag[c] = 8'(accq[c][0]);
            end
            msv[c]     = arv[c];
            mst_tag[c] = artag[c];
        end
        #1;
        model(r);
        for (int c = 0; c < 2; c++) begin
            if (r) begin
                pend[c] = '{1'b0, 1'b0};
                accq[c].delete();
                arv[c] = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++)
                    if (rqv[c][i] && rqr[c][i]) pend[c][i] = 1'b0;
                if (mqv[c] && mqr[c]) accq[c].push_back(int'(mqt[c]));
                if (msv[c] && msr[c]) begin
                    if (accq[c].size() > 0) void'(accq[c].pop_front());
                    arv[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic phase(input int n, input int unsigned pq, input int unsigned pm,
                         input int unsigned ps, input int unsigned pr);
        p_req  = pq;
        p_mrdy = pm;
        p_rsp  = ps;
        p_rrdy = pr;
        for (int k = 0; k < n; k++) cycle(1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        int   q;
        forever begin
            @(negedge clk);
            #2;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                for (int c = 0; c < 2; c++) begin
                    chk("mst_req_valid", c, 0, 32'(mqv[c]), 32'(e.mv[c]));
                    if (e.mv[c]) begin
                        chk("mst_req_tag", c, 0, 32'(mqt[c]), 32'(e.mt[c]));
                        chk("mst_req_instr", c, 0, mqi[c], e.mi[c]);
                    end
                    chk("mst_rsp_ready", c, 0, 32'(msr[c]), 32'(e.mrr[c]));
                    for (int i = 0; i < 2; i++) begin
                        chk("slv_req_ready", c, i, 32'(rqr[c][i]), 32'(e.rdy[c][i]));
                        chk("slv_rsp_valid", c, i, 32'(rsv[c][i]), 32'(e.rv[c][i]));
                    end
                end
            end
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 2; i++)
                    if (rsv[c][i] && rsr[c][i]) begin
                        q = c * 2 + i;
                        if (exq[q].size() == 0)
                            chk("rsp_unexpected", c, i, 32'd1, 32'd0);
                        else
                            chk("rsp_tag", c, i, 32'(rst_tag[c][i]),
                                32'(exq[q].pop_front()));
                    end
        end
    end

    initial begin : stim
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            ptr[c] = 0;
            lck[c] = -1;
            arv[c] = 1'b0;
            mqr[c] = 1'b0;
            msv[c] = 1'b0;
            mst_tag[c] = '0;
            artag[c] = '0;
            for (int i = 0; i < 2; i++) begin
                pend[c][i] = 1'b0;
                ptag[c][i] = '0;
                pins[c][i] = '0;
                rqv[c][i] = 1'b0;
                rqt[c][i] = '0;
                rqi[c][i] = '0;
                rsr[c][i] = 1'b0;
            end
        end
        msk = '{1'b1, 1'b1};
        p_req = 100; p_mrdy = 100; p_rsp = 100; p_rrdy = 100;
        cycle(1'b1);
        cycle(1'b1);
        phase(300, 50, 70, 60, 70);
        phase(200, 100, 100, 100, 100);
        phase(200, 100, 30, 70, 80);
        phase(200, 80, 90, 10, 50);
        phase(20, 100, 100, 0, 100);
        cycle(1'b1);
        phase(150, 60, 80, 60, 70);
        msk = '{1'b0, 1'b1};
        phase(100, 100, 100, 100, 100);
        msk = '{1'b1, 1'b0};
        phase(100, 70, 60, 40, 60);
        msk = '{1'b1, 1'b1};
        phase(100, 50, 50, 50, 50);
        p_req = 0;
        phase(40, 0, 100, 100, 100);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
